// File: rtl/imem_pkg.sv
// imem_pkg: shared loader state, error codes and instruction memory size
package imem_pkg;
  localparam int IMEM_BYTES = 256;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR} state_t;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;
endpackage

// File: rtl/loader_csum.sv
// loader_csum: 8-bit running payload sum; zero flags that sum plus the incoming byte wraps to 0
module loader_csum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] sum,
  output logic       zero
);
  always_ff @(posedge clk or posedge rst)
    if (rst) sum <= '0;
    else if (clr) sum <= '0;
    else if (en) sum <= sum + d;
  assign zero = (sum + d) == 8'd0;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: parses length/payload/checksum frames into instruction memory byte writes
module imem_loader import imem_pkg::*; #(
  parameter int MEM_BYTES = IMEM_BYTES,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [7:0]       wr_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [LEN_W-1:0] loaded_bytes
);
  state_t state;
  logic [LEN_W-1:0] len, cnt, len_n;
  logic [7:0] sum;
  logic xfer, restart, sum_ok;
  assign in_ready = state inside {LEN_HI, LEN_LO, DATA, CSUM};
  assign cpu_hold = in_ready;
  assign xfer = in_valid & in_ready;
  assign restart = start & (state inside {IDLE, DONE, ERR});
  assign len_n = {len[LEN_W-1:8], in_data};
  loader_csum u_csum (
    .clk (clk),
    .rst (rst),
    .clr (restart),
    .en  (xfer && state == DATA),
    .d   (in_data),
    .sum (sum),
    .zero(sum_ok)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      len          <= '0;
      cnt          <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      loaded_bytes <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR:
          if (start) begin
            state        <= LEN_HI;
            cnt          <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
            loaded_bytes <= '0;
          end
        LEN_HI:
          if (xfer) begin
            len[LEN_W-1:8] <= in_data;
            state          <= LEN_LO;
          end
        LEN_LO:
          if (xfer) begin
            len <= len_n;
            if (len_n > LEN_W'(MEM_BYTES)) begin
              state    <= ERR;
              err      <= 1'b1;
              err_code <= ERR_LEN;
            end else state <= len_n == '0 ? CSUM : DATA;
          end
        DATA:
          if (xfer) begin
            wr_en        <= 1'b1;
            wr_addr      <= 32'(cnt);
            wr_data      <= in_data;
            cnt          <= cnt + LEN_W'(1);
            loaded_bytes <= cnt + LEN_W'(1);
            if (cnt == len - LEN_W'(1)) state <= CSUM;
          end
        CSUM:
          if (xfer) begin
            state    <= sum_ok ? DONE : ERR;
            done     <= sum_ok;
            err      <= !sum_ok;
            err_code <= sum_ok ? ERR_NONE : ERR_CSUM;
          end
        default: state <= IDLE;
      endcase
    end
  logic unused;
  assign unused = ^sum;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frames checked against a frame-level reference model
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, wr_en, cpu_hold, done, err;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  err_code;
  logic [15:0] loaded_bytes;
  int total = 0, bad = 0;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err), .err_code(err_code),
    .loaded_bytes(loaded_bytes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // vp: percent chance in_valid is offered per cycle; -1 toggles every other cycle
  task automatic run(input logic [7:0] f[$], input int vp, input bit mid_start);
    int L, nw, idx, wcount, cyc;
    logic [7:0] s;
    logic [1:0] code;
    bit ok, fin, acc;
    L = {f[0], f[1]};
    s = 8'd0;
    if (L > 256) begin
      nw = 0; ok = 0; code = 2'b01;
    end else begin
      nw = L;
      for (int i = 0; i < L; i++) s = s + f[2 + i];
      ok = (8'(s + f[L + 2]) == 8'd0);
      code = ok ? 2'b00 : 2'b10;
    end
    @(posedge clk); #1 start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    idx = 0; wcount = 0; cyc = 0; fin = 0;
    while (!fin && cyc < 3000) begin
      in_valid = (idx < f.size()) && (vp < 0 ? (cyc % 2 == 0) : ($urandom_range(99) < vp));
      in_data = in_valid ? f[idx] : 8'($urandom);
      @(negedge clk);
      if (wr_en) begin
        chk("wr_addr", wr_addr, wcount);
        if (wcount < nw) chk("wr_data", wr_data, f[2 + wcount]);
        else chk("extra_write", 1, 0);
        wcount++;
      end
      fin = done | err;
      chk("cpu_hold", cpu_hold, !fin);
      acc = in_valid & in_ready;
      start = mid_start && !fin && $urandom_range(9) == 0;
      @(posedge clk); #1 start = 1'b0;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    if (!fin) chk("timeout", 0, 1);
    chk("done", done, ok);
    chk("err", err, !ok);
    chk("err_code", err_code, code);
    chk("loaded_bytes", loaded_bytes, nw);
    chk("write_count", wcount, nw);
    repeat (3) begin
      @(negedge clk);
      chk("idle_wr_en", wr_en, 0);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_hold", cpu_hold, 0);
    end
    chk("sticky_done", done, ok);
  endtask

  task automatic rst_test();
    logic [7:0] f[$] = '{8'h00, 8'h04, 8'h20, 8'h08, 8'h00, 8'h05, 8'hD3};
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = f[i];
      @(posedge clk); #1;
    end
    in_data = f[4];
    chk("pre_rst_wr_en", wr_en, 1);
    chk("pre_rst_loaded", loaded_bytes, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_outs", {in_ready, wr_en, cpu_hold, done, err, err_code}, 0);
    chk("arst_addr", wr_addr, 0);
    chk("arst_data", wr_data, 0);
    chk("arst_loaded", loaded_bytes, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_wr_en", wr_en, 0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_wr_en", wr_en, 0);
      chk("post_rst_ready", in_ready, 0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] s;
    int L;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #12;
    chk("reset_outs", {in_ready, wr_en, cpu_hold, done, err, err_code}, 0);
    chk("reset_loaded", loaded_bytes, 0);
    chk("reset_addr", wr_addr, 0);
    @(negedge clk); rst = 1'b0;
    f = '{8'h00, 8'h04, 8'h20, 8'h08, 8'h00, 8'h05, 8'hD3};
    run(f, 100, 0);
    f[6] = 8'hD4;
    run(f, 100, 0);
    f = '{8'h01, 8'h01, 8'hAA, 8'hBB};
    run(f, 100, 0);
    f = '{8'h00, 8'h00, 8'h00};
    run(f, 100, 0);
    f = '{8'h00, 8'h00, 8'h01};
    run(f, 100, 0);
    f = '{8'h00, 8'h04, 8'h20, 8'h08, 8'h00, 8'h05, 8'hD3};
    run(f, -1, 1);
    rst_test();
    f = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) f.push_back(8'(i));
    f.push_back(8'h80);
    run(f, 100, 0);
    for (int n = 0; n < 10; n++) begin
      L = ($urandom_range(5) == 0) ? $urandom_range(257, 400) : $urandom_range(0, 40);
      if (n == 9) L = 256;
      f = '{8'(L >> 8), 8'(L)};
      s = 8'd0;
      for (int i = 0; i < L && L <= 256; i++) begin
        f.push_back(8'($urandom));
        s = s + f[f.size() - 1];
      end
      f.push_back(($urandom_range(3) == 0) ? 8'(-s + 8'($urandom_range(1, 255))) : 8'(-s));
      run(f, $urandom_range(30, 100), 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
